// File: rtl/mem_copy_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_copy_engine: word-by-word memory block copier, 2 cycles per word.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_copy_engine #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_adr,
   input  logic [31:0]      dst_adr,
   input  logic [CNT_W-1:0] word_count,
   output logic [31:0]      adr,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [31:0]      WriteData,
   input  logic [31:0]      ReadData,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] words_left
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [31:0]      r_src_ptr;
   logic [31:0]      r_dst_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_data;
   logic [31:0]      r_adr;
   logic             r_mem_read;
   logic             r_mem_write;
   logic [31:0]      r_wdata;
   logic             r_busy;
   logic             r_done;

   logic [31:0]      w_src_al;
   logic [31:0]      w_dst_al;
   logic [31:0]      w_src_next;
   logic [31:0]      w_dst_next;
   logic             w_unused_bits;

   assign w_src_al      = {src_adr[31:2], 2'b00};
   assign w_dst_al      = {dst_adr[31:2], 2'b00};
   assign w_src_next    = r_src_ptr + 32'd4;
   assign w_dst_next    = r_dst_ptr + 32'd4;
   assign w_unused_bits = ^{src_adr[1:0], dst_adr[1:0]};

   // Outputs are registered alongside the state so they reflect the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_cnt       <= '0;
         r_data      <= '0;
         r_adr       <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src_ptr <= w_src_al;
                  r_dst_ptr <= w_dst_al;
                  r_cnt     <= word_count;
                  if (word_count == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_READ;
                     r_mem_read <= 1'b1;
                     r_adr      <= w_src_al;
                     r_busy     <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_data      <= ReadData;
               r_state     <= S_WRITE;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b1;
               r_adr       <= r_dst_ptr;
               r_wdata     <= ReadData;
            end
            S_WRITE: begin
               r_src_ptr   <= w_src_next;
               r_dst_ptr   <= w_dst_next;
               r_cnt       <= r_cnt - CNT_W'(1);
               r_mem_write <= 1'b0;
               r_wdata     <= '0;
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_DONE;
                  r_adr   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= S_READ;
                  r_mem_read <= 1'b1;
                  r_adr      <= w_src_next;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_adr       <= '0;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
               r_wdata     <= '0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign adr        = r_adr;
   assign MemRead    = r_mem_read;
   assign MemWrite   = r_mem_write;
   assign WriteData  = r_wdata;
   assign busy       = r_busy;
   assign done       = r_done;
   assign words_left = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// Directed testbench for mem_copy_engine with a combinational-read memory model.
module tb_mem_copy_engine;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          run = 1'b0;
   logic          rst;
   logic          start;
   logic [31:0]   src_adr;
   logic [31:0]   dst_adr;
   logic [CW-1:0] word_count;
   logic [31:0]   adr;
   logic          MemRead;
   logic          MemWrite;
   logic [31:0]   WriteData;
   logic [31:0]   ReadData;
   logic          busy;
   logic          done;
   logic [CW-1:0] words_left;

   logic [31:0]   mem [0:1023];

   int n_assert = 0;
   int n_fail   = 0;

   mem_copy_engine #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_adr    (src_adr),
      .dst_adr    (dst_adr),
      .word_count (word_count),
      .adr        (adr),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .busy       (busy),
      .done       (done),
      .words_left (words_left)
   );

   always #5 if (run) clk = ~clk;

   assign ReadData = mem[adr[11:2]];
   always @(posedge clk) if (MemWrite) mem[adr[11:2]] <= WriteData;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues a start and observes up to 2N+4 cycles following the start edge.
   task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit inject, output int done_cyc, output int rd,
                          output int wr, output int bsy, output int dn);
      done_cyc = 0; rd = 0; wr = 0; bsy = 0; dn = 0;
      @(negedge clk);
      src_adr = s; dst_adr = d; word_count = CW'(n); start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; src_adr = 32'hFFFF_FFFF; dst_adr = 32'hFFFF_FFFF; word_count = '1;
      for (int c = 1; c <= 2 * n + 4; c++) begin
         @(negedge clk);
         if (inject && c == 2) begin
            start = 1'b1; src_adr = 32'd0; dst_adr = 32'd3000; word_count = CW'(5);
         end else begin
            start = 1'b0;
         end
         if (MemRead) rd++;
         if (MemWrite) wr++;
         if (busy) bsy++;
         if (MemRead && MemWrite) chk("rd_wr_exclusive", 32'd1, 32'd0);
         if (done) begin
            dn++;
            if (done_cyc == 0) done_cyc = c;
         end
         if ((c % 2) == 1 && c < 2 * n)
            chk("words_left_step", 32'(words_left), 32'(n - (c - 1) / 2));
      end
   endtask

   int dc, rd, wr, bs, dn;

   initial begin
      rst = 1'b0; start = 1'b0; src_adr = '0; dst_adr = '0; word_count = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

      // Reset with the clock stopped.
      #3 rst = 1'b1;
      #1;
      chk("rst_adr", adr, 32'd0);
      chk("rst_memread", 32'(MemRead), 32'd0);
      chk("rst_memwrite", 32'(MemWrite), 32'd0);
      chk("rst_wdata", WriteData, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_words_left", 32'(words_left), 32'd0);
      #2 rst = 1'b0;
      run = 1'b1;

      // Basic copy of three words.
      mem[250] = 32'd11; mem[251] = 32'd22; mem[252] = 32'd33;
      do_copy(32'd1000, 32'd2000, 3, 1'b0, dc, rd, wr, bs, dn);
      chk("basic_m2000", mem[500], 32'd11);
      chk("basic_m2004", mem[501], 32'd22);
      chk("basic_m2008", mem[502], 32'd33);
      chk("basic_done_cycle", 32'(dc), 32'd7);
      chk("basic_write_cycles", 32'(wr), 32'd3);
      chk("basic_read_cycles", 32'(rd), 32'd3);
      chk("basic_busy_cycles", 32'(bs), 32'd6);
      chk("basic_done_count", 32'(dn), 32'd1);
      chk("basic_words_left_end", 32'(words_left), 32'd0);

      // Zero count.
      do_copy(32'd1000, 32'd2100, 0, 1'b0, dc, rd, wr, bs, dn);
      chk("zero_done_cycle", 32'(dc), 32'd1);
      chk("zero_reads", 32'(rd), 32'd0);
      chk("zero_writes", 32'(wr), 32'd0);
      chk("zero_busy", 32'(bs), 32'd0);
      chk("zero_done_count", 32'(dn), 32'd1);

      // Misaligned addresses, plus a start pulse while busy that must be ignored.
      mem[250] = 32'h0000_00AB; mem[500] = 32'h0; mem[750] = 32'h5A5A_5A5A;
      do_copy(32'd1003, 32'd2002, 1, 1'b1, dc, rd, wr, bs, dn);
      chk("misalign_m2000", mem[500], 32'h0000_00AB);
      chk("misalign_done_cycle", 32'(dc), 32'd3);
      chk("ignored_start_done_count", 32'(dn), 32'd1);
      chk("ignored_start_m3000", mem[750], 32'h5A5A_5A5A);
      chk("ignored_start_busy_after", 32'(busy), 32'd0);

      // Overlapping regions, ascending order.
      mem[250] = 32'd1; mem[251] = 32'd2; mem[252] = 32'd3;
      do_copy(32'd1000, 32'd1004, 2, 1'b0, dc, rd, wr, bs, dn);
      chk("overlap_m1004", mem[251], 32'd1);
      chk("overlap_m1008", mem[252], 32'd1);
      chk("overlap_m1000", mem[250], 32'd1);

      // Reset mid-copy after the second write edge.
      mem[250] = 32'd5; mem[251] = 32'd6; mem[252] = 32'd7; mem[253] = 32'd8;
      for (int i = 500; i < 504; i++) mem[i] = 32'hDEAD;
      @(negedge clk);
      src_adr = 32'd1000; dst_adr = 32'd2000; word_count = CW'(4); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_memread", 32'(MemRead), 32'd0);
      chk("midrst_memwrite", 32'(MemWrite), 32'd0);
      chk("midrst_adr", adr, 32'd0);
      chk("midrst_words_left", 32'(words_left), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("midrst_no_done", 32'(dn), 32'd0);
      chk("midrst_m2000", mem[500], 32'd5);
      chk("midrst_m2004", mem[501], 32'd6);
      chk("midrst_m2008", mem[502], 32'hDEAD);
      chk("midrst_m200c", mem[503], 32'hDEAD);

      // Fresh copy after the mid-copy reset.
      do_copy(32'd1008, 32'd2008, 2, 1'b0, dc, rd, wr, bs, dn);
      chk("fresh_m2008", mem[502], 32'd7);
      chk("fresh_m200c", mem[503], 32'd8);
      chk("fresh_done_cycle", 32'(dc), 32'd5);
      chk("fresh_done_count", 32'(dn), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
